// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Pipeline writeback stage. Queues execute results in an
//               in-order FIFO and drains them to the register-file write port
//               with a setup / strobe / gap handshake and a pending-write mask.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_AW-1:0]         in_reg,
    input  logic [DATA_W-1:0]         in_val,
    output logic [REG_AW-1:0]         destReg,
    output logic [DATA_W-1:0]         destVal,
    output logic                      storeNow,
    input  logic                      storeDone,
    output logic [(1<<REG_AW)-1:0]    pending,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      idle,
    output logic                      err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int NREG   = 1 << REG_AW;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_STROBE = 2'd2;
    localparam logic [1:0] c_GAP    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;

    logic [REG_AW-1:0] r_memReg [DEPTH];
    logic [DATA_W-1:0] r_memVal [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait;
    logic [REG_AW-1:0] r_destReg;
    logic [DATA_W-1:0] r_destVal;
    logic              r_err;

    logic              w_push;
    logic              w_pop;
    logic              w_timeout;
    logic              w_loadHead;
    logic [PTR_W-1:0]  w_off;
    logic [NREG-1:0]   w_pending;

    // Readiness comes from the registered count, so a same-edge pop never frees a slot early
    assign in_ready   = (r_count != CNT_W'(DEPTH));
    assign w_push     = in_valid && in_ready;
    assign w_timeout  = (r_wait == WAIT_W'(TIMEOUT - 1));
    assign w_pop      = (r_state == c_STROBE) && (storeDone || w_timeout);
    assign w_loadHead = (w_nextState == c_SETUP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:   if (r_count != '0) w_nextState = c_SETUP;
            c_SETUP:  w_nextState = c_STROBE;
            c_STROBE: if (w_pop) w_nextState = c_GAP;
            c_GAP:    w_nextState = (r_count != '0) ? c_SETUP : c_IDLE;
            default:  w_nextState = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        storeNow = (r_state == c_STROBE);
        idle     = (r_count == '0) && (r_state == c_IDLE);
        count    = r_count;
        destReg  = r_destReg;
        destVal  = r_destVal;
        err      = r_err;
        pending  = w_pending;
    end

    // FIFO storage; only entries inside the occupied window are ever observed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memReg[r_wrPtr] <= in_reg;
            r_memVal[r_wrPtr] <= in_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Strobe wait counter, sticky timeout flag and write-port address/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait    <= '0;
            r_err     <= 1'b0;
            r_destReg <= '0;
            r_destVal <= '0;
        end else begin
            if (r_state == c_STROBE && !storeDone && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (r_state == c_STROBE && !storeDone && w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_loadHead) begin
                r_destReg <= r_memReg[r_rdPtr];
                r_destVal <= r_memVal[r_rdPtr];
            end
        end
    end

    // Pending mask: every entry between read pointer and read pointer + count
    always_comb begin
        w_pending = '0;
        w_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PTR_W'(i) - r_rdPtr;
            if ({1'b0, w_off} < r_count) begin
                w_pending[r_memReg[i]] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Directed self-checking bench for writeback_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

    localparam int DEPTH   = 4;
    localparam int DATA_W  = 16;
    localparam int REG_AW  = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [REG_AW-1:0] in_reg = '0;
    logic [DATA_W-1:0] in_val = '0;
    logic [REG_AW-1:0] destReg;
    logic [DATA_W-1:0] destVal;
    logic              storeNow;
    logic              storeDone = 1'b0;
    logic [15:0]       pending;
    logic [2:0]        count;
    logic              idle;
    logic              err;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;

    writeback_unit #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_AW(REG_AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_val(in_val),
        .destReg(destReg), .destVal(destVal),
        .storeNow(storeNow), .storeDone(storeDone),
        .pending(pending), .count(count), .idle(idle), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records each completed write with its strobe length
    logic [REG_AW-1:0] sReg;
    logic [DATA_W-1:0] sVal;
    int sLen = 0;
    bit inStrobe = 0;
    int unstable = 0;
    int highSamples = 0;
    int logReg[$];
    int logVal[$];
    int logLen[$];
    int logCyc[$];

    always @(negedge clk) begin
        if (rst) begin
            inStrobe = 0;
        end else if (storeNow) begin
            highSamples++;
            if (!inStrobe) begin
                inStrobe = 1;
                sReg = destReg;
                sVal = destVal;
                sLen = 1;
            end else begin
                sLen++;
                if (destReg != sReg || destVal != sVal) unstable++;
            end
        end else if (inStrobe) begin
            inStrobe = 0;
            logReg.push_back(int'(sReg));
            logVal.push_back(int'(sVal));
            logLen.push_back(sLen);
            logCyc.push_back(cyc);
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input int v);
        in_valid = 1'b1;
        in_reg   = REG_AW'(r);
        in_val   = DATA_W'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic waitWrites(input string tag, input int n, input int budget);
        int k = 0;
        while (logVal.size() < n && k < budget) begin
            step();
            k++;
        end
        checkEq(tag, logVal.size(), n);
    endtask

    task automatic waitStrobe(input string tag, input int budget);
        int k = 0;
        while (!storeNow && k < budget) begin
            step();
            k++;
        end
        checkEq(tag, storeNow, 1);
    endtask

    initial begin
        int base;
        int hs;

        step();
        step();
        rst = 1'b0;
        #1;
        checkEq("rst_count",    count, 0);
        checkEq("rst_pending",  pending, 0);
        checkEq("rst_in_ready", in_ready, 1);
        checkEq("rst_idle",     idle, 1);
        checkEq("rst_storeNow", storeNow, 0);
        checkEq("rst_destReg",  destReg, 0);
        checkEq("rst_destVal",  destVal, 0);
        checkEq("rst_err",      err, 0);

        // Single write, storeDone tied high (ignored outside STROBE)
        storeDone = 1'b1;
        push(3, 16'hBEEF);                       // edge t0
        checkEq("t0_count",    count, 1);
        checkEq("t0_pending",  pending, 16'h0008);
        checkEq("t0_storeNow", storeNow, 0);
        step();                                  // t1: SETUP
        checkEq("t1_destReg",  destReg, 3);
        checkEq("t1_destVal",  destVal, 16'hBEEF);
        checkEq("t1_storeNow", storeNow, 0);
        checkEq("t1_pending",  pending, 16'h0008);
        step();                                  // t2: STROBE
        checkEq("t2_storeNow", storeNow, 1);
        step();                                  // t3: GAP
        checkEq("t3_storeNow", storeNow, 0);
        checkEq("t3_pending",  pending, 0);
        checkEq("t3_count",    count, 0);
        checkEq("t3_idle",     idle, 0);
        checkEq("t3_destVal",  destVal, 16'hBEEF);
        step();                                  // t4: IDLE
        checkEq("t4_idle",     idle, 1);

        // Fill to DEPTH, full backpressure, then in-order back-to-back drain
        base = logVal.size();
        storeDone = 1'b0;
        push(1, 16'h0011);
        push(2, 16'h0022);
        push(3, 16'h0033);
        checkEq("fill_ready3", in_ready, 1);
        push(4, 16'h0044);
        checkEq("fill_full_ready", in_ready, 0);
        checkEq("fill_full_count", count, 4);
        in_valid  = 1'b1;
        in_reg    = 4'd5;
        in_val    = 16'h0055;
        storeDone = 1'b1;
        step();                                  // pop while full: push refused
        checkEq("full_pop_count", count, 3);
        checkEq("full_pop_ready", in_ready, 1);
        step();                                  // fifth accepted
        in_valid = 1'b0;
        checkEq("fifth_count", count, 4);
        checkEq("fill_pending", pending, 16'h003C);
        waitWrites("fill_drain", base + 5, 40);
        for (int i = 0; i < 5; i++) begin
            if (logVal.size() > base + i) begin
                checkEq($sformatf("order_reg%0d", i), logReg[base+i], i + 1);
                checkEq($sformatf("order_val%0d", i), logVal[base+i], (i + 1) * 16'h0011);
                if (i > 0) begin
                    checkEq($sformatf("spacing%0d", i), logCyc[base+i] - logCyc[base+i-1], 3);
                    checkEq($sformatf("strobe_len%0d", i), logLen[base+i], 1);
                end
            end
        end
        step();
        checkEq("fill_idle", idle, 1);

        // Same-register ordering
        base = logVal.size();
        push(7, 16'h1111);
        push(7, 16'h2222);
        waitWrites("same_first", base + 1, 20);
        checkEq("same_pending_mid", pending[7], 1);
        waitWrites("same_second", base + 2, 20);
        checkEq("same_pending_end", pending, 0);
        if (logVal.size() >= base + 2)
            checkEq("same_last_val", logVal[base+1], 16'h2222);

        // Slow acknowledge: five STROBE cycles without storeDone
        base = logVal.size();
        storeDone = 1'b0;
        push(9, 16'hA5A5);
        waitStrobe("slow_strobe", 10);
        for (int i = 0; i < 5; i++) step();
        checkEq("slow_still_high", storeNow, 1);
        storeDone = 1'b1;
        step();
        checkEq("slow_dropped", storeNow, 0);
        waitWrites("slow_logged", base + 1, 5);
        if (logLen.size() >= base + 1) begin
            checkEq("slow_len", logLen[base], 6);
            checkEq("slow_val", logVal[base], 16'hA5A5);
        end
        checkEq("slow_err", err, 0);
        checkEq("stable_strobes", unstable, 0);

        // Timeout: stuck acknowledge, forced pop, sticky err, next entry proceeds
        base = logVal.size();
        storeDone = 1'b0;
        push(2, 16'h0F0F);
        push(4, 16'h4444);
        waitWrites("to_first", base + 1, 40);
        checkEq("to_err_set", err, 1);
        if (logLen.size() >= base + 1) begin
            checkEq("to_len", logLen[base], TIMEOUT);
            checkEq("to_reg", logReg[base], 2);
        end
        storeDone = 1'b1;
        waitWrites("to_second", base + 2, 20);
        if (logVal.size() >= base + 2)
            checkEq("to_next_val", logVal[base+1], 16'h4444);
        checkEq("to_err_sticky", err, 1);

        // Reset in the middle of a strobe with three entries queued
        storeDone = 1'b0;
        push(10, 16'h000A);
        push(11, 16'h000B);
        push(12, 16'h000C);
        waitStrobe("rstmid_strobe", 10);
        #2;
        rst = 1'b1;
        #1;
        checkEq("rstmid_storeNow", storeNow, 0);
        checkEq("rstmid_count",    count, 0);
        checkEq("rstmid_pending",  pending, 0);
        checkEq("rstmid_ready",    in_ready, 1);
        checkEq("rstmid_err",      err, 0);
        step();
        step();
        rst = 1'b0;
        storeDone = 1'b1;
        base = logVal.size();
        hs = highSamples;
        for (int i = 0; i < 20; i++) step();
        checkEq("rstmid_no_writes",  logVal.size(), base);
        checkEq("rstmid_no_strobes", highSamples, hs);
        checkEq("rstmid_idle",       idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage of the 3-stage pipeline. It is the initiator side of the register-file write port.
- Accepts execute-stage results (dest register, value) over a valid/ready handshake and buffers them in an in-order FIFO.
- Drains each entry to the register file by driving destReg/destVal and strobing storeNow, then waiting for storeDone.
- Publishes a pending-write mask so decode can stall on registers that still have writes outstanding.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DATA_W, 16, register value width.
- REG_AW, 4, register address width (16 registers).
- TIMEOUT, 15, maximum STROBE cycles waiting for storeDone before forced completion.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  execute result present.
- in_ready  output  1  FIFO can accept; equals not full.
- in_reg  input  REG_AW  destination register of result.
- in_val  input  DATA_W  result value.
- destReg  output  REG_AW  register-file write address.
- destVal  output  DATA_W  register-file write data.
- storeNow  output  1  write strobe to register file.
- storeDone  input  1  register file write-complete acknowledge.
- pending  output  2**REG_AW  bit r set while any queued or in-flight entry targets register r.
- count  output  clog2(DEPTH)+1  occupied FIFO entries, including the in-flight head.
- idle  output  1  FIFO empty and FSM in IDLE.
- err  output  1  sticky; set on timeout.

Behaviour:
- Reset, asynchronous and immediate:
  - FIFO emptied; count=0; pending=0; in_ready=1.
  - destReg=0; destVal=0; storeNow=0.
  - FSM in IDLE; idle=1; err=0.
  - Reset mid-write drops storeNow at once; the in-flight entry and all queued entries are discarded.
- Push: on a clk edge with in_valid && in_ready, {in_reg, in_val} is written at the tail.
  - in_ready is derived from count before the edge. When full, no push is accepted, even if a pop happens on the same edge.
- Pop: the head is removed only on the edge that leaves STROBE.
  - Simultaneous push and pop with the FIFO neither empty nor full: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: storeNow=0. If count!=0, go to SETUP on the next edge.
  - SETUP: destReg/destVal = head entry, registered. storeNow=0. Always go to STROBE. This gives one cycle of address/data setup before the strobe.
  - STROBE: storeNow=1; destReg/destVal held.
    - storeDone is qualified only in STROBE; its level in any other state is ignored.
    - If storeDone=1 on an edge: pop, go to GAP.
    - Otherwise the wait counter increments. When the counter reaches TIMEOUT: set err, pop anyway, go to GAP.
  - GAP: storeNow=0; destReg/destVal still held. Gives at least one low cycle between strobes. If count!=0 after the pop, go to SETUP, else go to IDLE.
- Latency and throughput:
  - Push at edge t0 gives SETUP at t1, storeNow high from t2, pop at t3 at the earliest, GAP at t3.
  - Back-to-back writes complete one per 3 cycles (SETUP, STROBE, GAP).
- pending:
  - Combinational OR of the one-hot decodes of in_reg over all valid FIFO entries, including the head until its pop edge.
  - Duplicate targets are allowed; the bit clears only when the last entry for that register pops.
- Ordering: strictly FIFO. Two writes to the same register are issued in arrival order, so the later value wins.
- idle = (count==0) && IDLE.

Test Plan:
- Single write:
  - Stimulus: reset, push R3=0xBEEF with storeDone tied high.
  - Required response: destReg=3 and destVal=0xBEEF at t1; storeNow high only during t2; pending[3]=1 from t1 until t3; idle at t4.
- Back-to-back, fill and backpressure:
  - Stimulus: push 5 results (R1..R5 = 0x0011..0x0055) on consecutive cycles, DEPTH=4.
  - Required response: in_ready falls after the 4th push; the 5th is accepted after the first pop; writes appear in order, one per 3 cycles; storeNow has a low cycle between every strobe.
- Same-register ordering:
  - Stimulus: push R7=0x1111, then R7=0x2222.
  - Required response: pending[7] stays 1 until the second pop; the final destVal strobed is 0x2222.
- Slow acknowledge:
  - Stimulus: hold storeDone=0 for 5 STROBE cycles, then 1.
  - Required response: storeNow stays high 6 cycles; destReg/destVal are stable throughout; err=0.
- Timeout:
  - Stimulus: storeDone stuck at 0.
  - Required response: the entry pops after TIMEOUT=15 STROBE cycles; err=1 and remains set; the next entry proceeds.
- Reset mid-operation:
  - Stimulus: assert rst during STROBE with 3 entries queued.
  - Required response: storeNow=0 immediately; count=0; pending=0; in_ready=1; no further strobes after rst falls.
